// File: rtl/duc_cfg_sequencer.sv
// rtl/duc_cfg_sequencer.sv - atomic DUC reconfiguration sequencer (shadow regs, timed commit, gated run)
module duc_cfg_sequencer #(
    parameter int BASE         = 0,
    parameter int DRAIN_CYCLES = 16,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sh_stb,
    input  logic [1:0]  i_sh_addr,
    input  logic [31:0] i_sh_data,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_timed,
    input  logic [31:0] i_cmd_time,
    input  logic [31:0] i_now_time,
    input  logic        i_abort,
    input  logic        i_run_in,
    output logic        o_run_out,
    output logic        o_set_stb,
    output logic [7:0]  o_set_addr,
    output logic [31:0] o_set_data,
    output logic        o_clr,
    output logic        o_busy,
    output logic        o_late,
    output logic        o_done
);

    localparam int MAX_CNT = (DRAIN_CYCLES > FLUSH_CYCLES) ? DRAIN_CYCLES : FLUSH_CYCLES;
    localparam int CW      = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CW-1:0] FLUSH_LAST = CW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_WR0,
        S_WR1,
        S_WR2,
        S_CLR,
        S_FLUSH
    } state_t;

    // A zero-length drain or flush phase is skipped entirely.
    localparam state_t S_START     = (DRAIN_CYCLES == 0) ? S_WR0  : S_DRAIN;
    localparam state_t S_AFTER_CLR = (FLUSH_CYCLES == 0) ? S_IDLE : S_FLUSH;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;

    logic [31:0]     r_sh_phase;
    logic [17:0]     r_sh_scale;
    logic [9:0]      r_sh_rate;
    logic [31:0]     r_act_phase;
    logic [17:0]     r_act_scale;
    logic [9:0]      r_act_rate;
    logic [31:0]     r_cmd_time;

    logic            r_gate;
    logic            r_cmd_ready;
    logic            r_set_stb;
    logic [7:0]      r_set_addr;
    logic [31:0]     r_set_data;
    logic            r_clr;
    logic            r_busy;
    logic            r_late;
    logic            r_done;

    logic            w_accept;
    logic [31:0]     w_late_diff;
    logic [31:0]     w_wait_diff;
    logic            w_late_now;
    logic            w_time_reached;
    logic [31:0]     w_act_phase;
    logic [17:0]     w_act_scale;
    logic [9:0]      w_act_rate;

    logic            w_gate;
    logic            w_set_stb;
    logic [7:0]      w_set_addr;
    logic [31:0]     w_set_data;
    logic            w_clr;
    logic            w_done;

    assign w_accept       = i_cmd_valid & r_cmd_ready;
    // Wrap-safe time comparisons: the sign of the modular difference decides order.
    assign w_late_diff    = i_now_time - i_cmd_time;
    assign w_wait_diff    = i_now_time - r_cmd_time;
    assign w_late_now     = i_cmd_timed & ~w_late_diff[31] & (w_late_diff != 32'd0);
    assign w_time_reached = ~w_wait_diff[31];

    // When the write phase follows acceptance directly, the snapshot is not yet in the active regs.
    assign w_act_phase = w_accept ? r_sh_phase : r_act_phase;
    assign w_act_scale = w_accept ? r_sh_scale : r_act_scale;
    assign w_act_rate  = w_accept ? r_sh_rate  : r_act_rate;

    // Shadow registers: written any cycle, unused high bits dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_phase <= '0;
            r_sh_scale <= '0;
            r_sh_rate  <= '0;
        end else if (i_sh_stb) begin
            case (i_sh_addr)
                2'd0:    r_sh_phase <= i_sh_data;
                2'd1:    r_sh_scale <= i_sh_data[17:0];
                2'd2:    r_sh_rate  <= i_sh_data[9:0];
                default: ;
            endcase
        end
    end

    // Snapshot shadows, commit time and lateness when a command is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_phase <= '0;
            r_act_scale <= '0;
            r_act_rate  <= '0;
            r_cmd_time  <= '0;
            r_late      <= 1'b0;
        end else if (w_accept) begin
            r_act_phase <= r_sh_phase;
            r_act_scale <= r_sh_scale;
            r_act_rate  <= r_sh_rate;
            r_cmd_time  <= i_cmd_time;
            r_late      <= w_late_now;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Phase counter: runs while staying in DRAIN or FLUSH, zero otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == S_DRAIN || r_state == S_FLUSH) && w_next == r_state) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (i_cmd_timed && !w_late_now) ? S_WAIT : S_START;
                end
            end
            S_WAIT: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (w_time_reached) begin
                    w_next = S_START;
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_next = S_WR0;
                end
            end
            S_WR0:   w_next = S_WR1;
            S_WR1:   w_next = S_WR2;
            S_WR2:   w_next = S_CLR;
            S_CLR:   w_next = S_AFTER_CLR;
            S_FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the next state so that every output is registered with its state.
    always_comb begin
        w_gate     = (w_next == S_IDLE) || (w_next == S_WAIT);
        w_set_stb  = 1'b0;
        w_set_addr = '0;
        w_set_data = '0;
        w_clr      = (w_next == S_CLR);
        w_done     = (r_state == S_FLUSH || r_state == S_CLR) && (w_next == S_IDLE);
        case (w_next)
            S_WR0: begin
                w_set_stb  = 1'b1;
                w_set_addr = 8'(BASE);
                w_set_data = w_act_phase;
            end
            S_WR1: begin
                w_set_stb  = 1'b1;
                w_set_addr = 8'(BASE + 1);
                w_set_data = {14'd0, w_act_scale};
            end
            S_WR2: begin
                w_set_stb  = 1'b1;
                w_set_addr = 8'(BASE + 2);
                w_set_data = {22'd0, w_act_rate};
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gate      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_set_stb   <= 1'b0;
            r_set_addr  <= '0;
            r_set_data  <= '0;
            r_clr       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_gate      <= w_gate;
            r_cmd_ready <= (w_next == S_IDLE);
            r_set_stb   <= w_set_stb;
            r_set_addr  <= w_set_addr;
            r_set_data  <= w_set_data;
            r_clr       <= w_clr;
            r_busy      <= (w_next != S_IDLE);
            r_done      <= w_done;
        end
    end

    assign o_run_out   = i_run_in & r_gate;
    assign o_cmd_ready = r_cmd_ready;
    assign o_set_stb   = r_set_stb;
    assign o_set_addr  = r_set_addr;
    assign o_set_data  = r_set_data;
    assign o_clr       = r_clr;
    assign o_busy      = r_busy;
    assign o_late      = r_late;
    assign o_done      = r_done;

endmodule

// File: tb/tb_duc_cfg_sequencer.sv
// tb/tb_duc_cfg_sequencer.sv - directed self-checking bench for duc_cfg_sequencer
module tb_duc_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sh_stb;
    logic [1:0]  sh_addr;
    logic [31:0] sh_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_timed;
    logic [31:0] cmd_time;
    logic [31:0] now_time;
    logic        abort;
    logic        run_in;
    logic        run_out;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        clr;
    logic        busy;
    logic        late;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    int          n_stb;
    int          stb_cyc [3];
    logic [7:0]  stb_addr [3];
    logic [31:0] stb_data [3];
    int          clr_cyc;
    int          done_cyc;
    int          n_low;
    int          first_low;
    int          last_low;
    int          n_ready_pre;

    duc_cfg_sequencer #(.BASE(0), .DRAIN_CYCLES(16), .FLUSH_CYCLES(64)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sh_stb    (sh_stb),
        .i_sh_addr   (sh_addr),
        .i_sh_data   (sh_data),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_timed (cmd_timed),
        .i_cmd_time  (cmd_time),
        .i_now_time  (now_time),
        .i_abort     (abort),
        .i_run_in    (run_in),
        .o_run_out   (run_out),
        .o_set_stb   (set_stb),
        .o_set_addr  (set_addr),
        .o_set_data  (set_data),
        .o_clr       (clr),
        .o_busy      (busy),
        .o_late      (late),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        now_time = now_time + 32'd1;
    endtask

    task automatic sh_write(input logic [1:0] a, input logic [31:0] d);
        sh_stb  = 1'b1;
        sh_addr = a;
        sh_data = d;
        tick();
        sh_stb  = 1'b0;
    endtask

    task automatic accept_now();
        cmd_valid = 1'b1;
        cmd_timed = 1'b0;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Records one sequence starting at relative cycle 1; optional shadow write to addr 1 at wr_cyc.
    task automatic observe(input int max_cyc, input int wr_cyc, input logic [31:0] wr_data);
        n_stb = 0; clr_cyc = -1; done_cyc = -1; n_low = 0;
        first_low = -1; last_low = -1; n_ready_pre = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (set_stb) begin
                if (n_stb < 3) begin
                    stb_cyc[n_stb]  = c;
                    stb_addr[n_stb] = set_addr;
                    stb_data[n_stb] = set_data;
                end
                n_stb++;
            end
            if (clr && clr_cyc < 0) clr_cyc = c;
            if (!run_out) begin
                n_low++;
                if (first_low < 0) first_low = c;
                last_low = c;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            if (cmd_ready) n_ready_pre++;
            sh_stb  = (c == wr_cyc);
            sh_addr = 2'd1;
            sh_data = wr_data;
            tick();
            sh_stb  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_checks++; if (run_out !== 1'b1) begin n_errors++; $display("FAIL reset_run_out: got %b want 1", run_out); end
        n_checks++; if ({set_stb, clr, busy, late, done} !== 5'b0) begin n_errors++; $display("FAIL reset_flags: got %b want 00000", {set_stb, clr, busy, late, done}); end
        n_checks++; if ({set_addr, set_data} !== 40'd0) begin n_errors++; $display("FAIL reset_bus: got %h want 0", {set_addr, set_data}); end
        run_in = 1'b0;
        #1;
        n_checks++; if (run_out !== 1'b0) begin n_errors++; $display("FAIL run_in_low: got %b want 0", run_out); end
        run_in = 1'b1;
        rst_n  = 1'b1;
        tick();
    endtask

    task automatic test_immediate();
        sh_write(2'd0, 32'h0100_0000);
        sh_write(2'd1, 32'h0000_C000);
        sh_write(2'd2, 32'hFFFF_F308);
        sh_write(2'd3, 32'hDEAD_BEEF);
        accept_now();
        observe(200, -1, 32'd0);
        n_checks++; if (n_stb !== 3) begin n_errors++; $display("FAIL imm_stb_count: got %0d want 3", n_stb); end
        n_checks++; if (stb_cyc[0] !== 17 || stb_cyc[1] !== 18 || stb_cyc[2] !== 19) begin n_errors++; $display("FAIL imm_stb_cycles: got %0d %0d %0d want 17 18 19", stb_cyc[0], stb_cyc[1], stb_cyc[2]); end
        n_checks++; if (stb_addr[0] !== 8'd0 || stb_addr[1] !== 8'd1 || stb_addr[2] !== 8'd2) begin n_errors++; $display("FAIL imm_addr: got %0d %0d %0d want 0 1 2", stb_addr[0], stb_addr[1], stb_addr[2]); end
        n_checks++; if (stb_data[0] !== 32'h0100_0000 || stb_data[1] !== 32'h0000_C000 || stb_data[2] !== 32'h0000_0308) begin n_errors++; $display("FAIL imm_data: got %h %h %h want 01000000 0000c000 00000308", stb_data[0], stb_data[1], stb_data[2]); end
        n_checks++; if (clr_cyc !== 20) begin n_errors++; $display("FAIL imm_clr_cycle: got %0d want 20", clr_cyc); end
        n_checks++; if (done_cyc !== 85) begin n_errors++; $display("FAIL imm_done_cycle: got %0d want 85", done_cyc); end
        n_checks++; if (first_low !== 1 || last_low !== 84 || n_low !== 84) begin n_errors++; $display("FAIL imm_run_gate: got first=%0d last=%0d n=%0d want 1 84 84", first_low, last_low, n_low); end
        n_checks++; if (n_ready_pre !== 0 || late !== 1'b0) begin n_errors++; $display("FAIL imm_ready_late: got ready_cycles=%0d late=%b want 0 0", n_ready_pre, late); end
        tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL imm_done_pulse: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_timed();
        logic [31:0] drop_now;
        logic        at_match_run;
        int          pre_stb;
        bit          found;
        pre_stb = 0; found = 1'b0; at_match_run = 1'b0; drop_now = '0;
        cmd_time  = now_time + 32'd1000;
        cmd_timed = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || late !== 1'b0 || run_out !== 1'b1) begin n_errors++; $display("FAIL timed_wait_entry: got busy=%b ready=%b late=%b run=%b want 1 0 0 1", busy, cmd_ready, late, run_out); end
        for (int c = 0; c < 1100; c++) begin
            if (set_stb) pre_stb++;
            if (now_time == cmd_time) at_match_run = run_out;
            if (!run_out) begin
                found = 1'b1;
                drop_now = now_time;
                break;
            end
            tick();
        end
        n_checks++; if (!found || drop_now !== cmd_time + 32'd1 || at_match_run !== 1'b1) begin n_errors++; $display("FAIL timed_drain_entry: got found=%0d now=%h run_at_match=%b want 1 %h 1", found, drop_now, at_match_run, cmd_time + 32'd1); end
        n_checks++; if (pre_stb !== 0) begin n_errors++; $display("FAIL timed_early_stb: got %0d want 0", pre_stb); end
        observe(200, -1, 32'd0);
        n_checks++; if (stb_cyc[0] !== 17 || n_stb !== 3 || done_cyc !== 85 || late !== 1'b0) begin n_errors++; $display("FAIL timed_sequence: got stb0=%0d n=%0d done=%0d late=%b want 17 3 85 0", stb_cyc[0], n_stb, done_cyc, late); end
        tick();
    endtask

    task automatic test_wrap();
        int wait_cnt;
        bit found;
        wait_cnt = 0; found = 1'b0;
        now_time  = 32'hFFFF_FFF0;
        cmd_time  = 32'h0000_0010;
        cmd_timed = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!run_out) begin
                found = 1'b1;
                break;
            end
            if (busy) wait_cnt++;
            tick();
        end
        n_checks++; if (!found || wait_cnt !== 32 || now_time !== 32'h0000_0011 || late !== 1'b0) begin n_errors++; $display("FAIL wrap_wait: got found=%0d waited=%0d now=%h late=%b want 1 32 00000011 0", found, wait_cnt, now_time, late); end
        observe(200, -1, 32'd0);
        n_checks++; if (done_cyc !== 85) begin n_errors++; $display("FAIL wrap_done: got %0d want 85", done_cyc); end
        tick();
    endtask

    task automatic test_late();
        cmd_time  = now_time - 32'd5;
        cmd_timed = 1'b1;
        cmd_valid = 1'b1;
        sh_stb    = 1'b1;
        sh_addr   = 2'd0;
        sh_data   = 32'h1234_5678;
        tick();
        cmd_valid = 1'b0;
        sh_stb    = 1'b0;
        n_checks++; if (late !== 1'b1 || run_out !== 1'b0) begin n_errors++; $display("FAIL late_flag: got late=%b run=%b want 1 0", late, run_out); end
        observe(200, -1, 32'd0);
        n_checks++; if (stb_cyc[0] !== 17 || clr_cyc !== 20 || done_cyc !== 85) begin n_errors++; $display("FAIL late_timing: got stb0=%0d clr=%0d done=%0d want 17 20 85", stb_cyc[0], clr_cyc, done_cyc); end
        n_checks++; if (stb_data[0] !== 32'h0100_0000 || stb_data[1] !== 32'h0000_C000 || stb_data[2] !== 32'h0000_0308) begin n_errors++; $display("FAIL late_data: got %h %h %h want 01000000 0000c000 00000308", stb_data[0], stb_data[1], stb_data[2]); end
        n_checks++; if (late !== 1'b1) begin n_errors++; $display("FAIL late_sticky: got %b want 1", late); end
        tick();
    endtask

    task automatic test_abort();
        int bad_stb;
        int bad_done;
        int bad_low;
        bad_stb = 0; bad_done = 0; bad_low = 0;
        cmd_time  = now_time + 32'd100;
        cmd_timed = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        n_checks++; if (busy !== 1'b1 || late !== 1'b0) begin n_errors++; $display("FAIL abort_wait_state: got busy=%b late=%b want 1 0", busy, late); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL abort_to_idle: got busy=%b ready=%b want 0 1", busy, cmd_ready); end
        for (int c = 0; c < 150; c++) begin
            if (set_stb) bad_stb++;
            if (done) bad_done++;
            if (!run_out) bad_low++;
            tick();
        end
        n_checks++; if (bad_stb !== 0 || bad_done !== 0 || bad_low !== 0) begin n_errors++; $display("FAIL abort_quiet: got stb=%0d done=%0d low=%0d want 0 0 0", bad_stb, bad_done, bad_low); end
        accept_now();
        abort = 1'b1;
        observe(200, -1, 32'd0);
        abort = 1'b0;
        n_checks++; if (n_stb !== 3 || done_cyc !== 85 || stb_data[0] !== 32'h1234_5678) begin n_errors++; $display("FAIL abort_in_drain: got n=%0d done=%0d d0=%h want 3 85 12345678", n_stb, done_cyc, stb_data[0]); end
        tick();
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1;
        cmd_timed = 1'b0;
        tick();
        observe(200, 30, 32'hFFF2_AAAA);
        n_checks++; if (stb_data[1] !== 32'h0000_C000 || done_cyc !== 85) begin n_errors++; $display("FAIL b2b_first: got scale=%h done=%0d want 0000c000 85", stb_data[1], done_cyc); end
        n_checks++; if (n_ready_pre !== 0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready: got early=%0d ready_at_done=%b want 0 1", n_ready_pre, cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        observe(200, -1, 32'd0);
        n_checks++; if (stb_data[1] !== 32'h0002_AAAA || stb_data[0] !== 32'h1234_5678 || stb_cyc[0] !== 17 || done_cyc !== 85) begin n_errors++; $display("FAIL b2b_second: got scale=%h phase=%h stb0=%0d done=%0d want 0002aaaa 12345678 17 85", stb_data[1], stb_data[0], stb_cyc[0], done_cyc); end
        tick();
    endtask

    task automatic test_reset_mid();
        int bad_stb;
        bad_stb = 0;
        accept_now();
        for (int c = 1; c < 18; c++) tick();
        n_checks++; if (set_stb !== 1'b1 || set_addr !== 8'd1) begin n_errors++; $display("FAIL mid_pre_reset: got stb=%b addr=%0d want 1 1", set_stb, set_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (run_out !== 1'b1 || set_stb !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL mid_reset_async: got run=%b stb=%b busy=%b ready=%b want 1 0 0 1", run_out, set_stb, busy, cmd_ready); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (set_stb) bad_stb++;
            tick();
        end
        n_checks++; if (bad_stb !== 0) begin n_errors++; $display("FAIL mid_dropped_writes: got %0d want 0", bad_stb); end
        accept_now();
        observe(200, -1, 32'd0);
        n_checks++; if (stb_data[0] !== 32'd0 || stb_data[1] !== 32'd0 || stb_data[2] !== 32'd0 || done_cyc !== 85) begin n_errors++; $display("FAIL mid_shadow_cleared: got %h %h %h done=%0d want 0 0 0 85", stb_data[0], stb_data[1], stb_data[2], done_cyc); end
    endtask

    initial begin
        rst_n     = 1'b0;
        sh_stb    = 1'b0;
        sh_addr   = 2'd0;
        sh_data   = 32'd0;
        cmd_valid = 1'b0;
        cmd_timed = 1'b0;
        cmd_time  = 32'd0;
        now_time  = 32'h0000_1000;
        abort     = 1'b0;
        run_in    = 1'b1;
        test_reset();
        test_immediate();
        test_timed();
        test_wrap();
        test_late();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/duc_cfg_sequencer.md
Name: duc_cfg_sequencer

Overview:
- Sequences atomic reconfiguration of one DUC chain: phase increment, scale factor, and the interp/half-band word.
- The host loads shadow registers, then issues a commit, either immediate or at a timestamp.
- On commit the block gates the TX run, writes three settings-bus words to the DUC at BASE+0..2, pulses clear, and waits a flush interval before re-enabling run.
- Sits between the host settings path and the DUC chain's set_stb/set_addr/set_data, clr and run inputs.

Parameters:
BASE, 0, settings address of the DUC's first register (phase_inc); BASE+1 is scale, BASE+2 is rate/hb word
DRAIN_CYCLES, 16, cycles run is held low before the first write
FLUSH_CYCLES, 64, cycles after clear before run is restored (covers CIC/HB/CORDIC pipeline)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sh_stb  in  1  shadow register write strobe
sh_addr  in  2  shadow address: 0 phase_inc, 1 scale[17:0], 2 {hb1,hb2,rate[7:0]}[9:0], 3 reserved (ignored)
sh_data  in  32  shadow write data
cmd_valid  in  1  commit request
cmd_ready  out  1  high only in IDLE
cmd_timed  in  1  1 = wait for cmd_time; 0 = execute now
cmd_time  in  32  commit timestamp
now_time  in  32  free-running time counter
abort  in  1  cancels a pending timed commit
run_in  in  1  run from TX control
run_out  out  1  gated run to DUC
set_stb  out  1  settings strobe to DUC
set_addr  out  8  settings address
set_data  out  32  settings data
clr  out  1  one-cycle clear to DUC
busy  out  1  state != IDLE
late  out  1  sticky: the last timed commit was already past on acceptance
done  out  1  one-cycle pulse on return to IDLE after writes complete

Behaviour:
- Reset (async, rst_n=0): state IDLE; shadow and active registers = 0; set_stb=0, set_addr=0, set_data=0, clr=0, late=0, done=0, counters=0. run_out = run_in & gate, with gate=1 at reset.
- Shadow writes are accepted every cycle in any state. Each write updates only the addressed shadow register; unused high bits are stored as 0.
- Handshake: a command is accepted when cmd_valid & cmd_ready. On acceptance:
  - all three shadow registers are snapshotted into active registers the same cycle;
  - cmd_time is latched;
  - late is cleared, then set if cmd_timed and signed(now_time - cmd_time) > 0;
  - a shadow write in the acceptance cycle lands in shadow only, not in the snapshot.
- FSM (all outputs registered):
  - IDLE: cmd_ready=1, gate=1. On acceptance go to WAIT if cmd_timed & ~late, else DRAIN.
  - WAIT: gate stays 1. When signed(now_time - cmd_time) >= 0 (wrap-safe), go to DRAIN. abort=1 returns to IDLE with no writes and no done. abort has priority over the time match in the same cycle.
  - DRAIN: gate=0; count DRAIN_CYCLES cycles, then WR0. abort is ignored from DRAIN onward.
  - WR0, WR1, WR2: one cycle each. set_stb=1, set_addr=BASE+n, set_data=active reg n zero-extended to 32 bits. The three strobes are back-to-back.
  - CLR: clr=1 for one cycle, set_stb=0.
  - FLUSH: count FLUSH_CYCLES cycles with gate=0. Then go to IDLE, gate=1, done=1 for one cycle.
- Latency, immediate commit: acceptance at cycle 0 → run_out low at cycle 1 → first set_stb at cycle 1+DRAIN_CYCLES → clr at 4+DRAIN_CYCLES → done at 5+DRAIN_CYCLES+FLUSH_CYCLES.
- Counters use clog2(max(DRAIN_CYCLES, FLUSH_CYCLES)+1) bits. A parameter value of 0 means that state lasts zero cycles (skipped).
- cmd_valid outside IDLE is not accepted and is not queued.
- Reset mid-sequence: writes already issued stay in the DUC, remaining writes are dropped, run_out follows run_in immediately.

Test Plan:
- Immediate commit: shadow 0x01000000/0x0C000/{1,1,8}, DRAIN=16, FLUSH=64 → set_stb at cycles 17, 18, 19 with addr BASE..BASE+2 and data 0x01000000, 0x0000C000, 0x00000308; clr at 20; done at 85; run_out low over 1..84.
- Timed commit: cmd_time = now+1000 → no set_stb before the match; DRAIN is entered the cycle now_time==cmd_time; late=0.
- Wrap: now=0xFFFFFFF0, cmd_time=0x00000010 → waits 32 cycles across the wrap; late=0.
- Late: cmd_time = now-5 → late=1, sequence runs immediately, writes identical to the immediate case.
- Abort in WAIT → IDLE next cycle, zero set_stb, no done; abort asserted in DRAIN → ignored, sequence completes.
- Shadow write to addr 1 during FLUSH plus cmd_valid held high throughout → current sequence's data unchanged; cmd_ready rises only after done; the second commit then carries the new scale value.
